// File: rtl/pixel_beat_pkg.sv
// Shared state encoding and default sizing for the pixel beat collector.
package pixel_beat_pkg;

    localparam int DEFAULT_BEATS             = 4;
    localparam int DEFAULT_DATAWIDTH         = 8;
    localparam int DEFAULT_PIXELCOUNTERWIDTH = 20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/beat_accumulator.sv
// Per-pixel running sum and beat counter; beats past BEATS are dropped and flagged.
module beat_accumulator
    import pixel_beat_pkg::*;
#(
    parameter int BEATS     = DEFAULT_BEATS,
    parameter int DATAWIDTH = DEFAULT_DATAWIDTH,
    parameter int SUMWIDTH  = DATAWIDTH + 4,
    parameter int CNTW      = $clog2(BEATS) + 1
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 beatValid,
    input  logic [DATAWIDTH-1:0] dataIn,
    output logic [SUMWIDTH-1:0]  sum,
    output logic [CNTW-1:0]      beatCnt,
    output logic                 overflow
);

    localparam logic [CNTW-1:0] BEATS_C = CNTW'(BEATS);

    logic [SUMWIDTH-1:0] sum_q, sum_d;
    logic [CNTW-1:0]     cnt_q, cnt_d;

    always_comb begin
        sum_d = sum_q;
        cnt_d = cnt_q;
        if (clear) begin
            sum_d = '0;
            cnt_d = '0;
        end else if (beatValid && (cnt_q != BEATS_C)) begin
            sum_d = sum_q + SUMWIDTH'(dataIn);
            cnt_d = cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
            cnt_q <= '0;
        end else begin
            sum_q <= sum_d;
            cnt_q <= cnt_d;
        end
    end

    assign sum      = sum_q;
    assign beatCnt  = cnt_q;
    assign overflow = beatValid && (cnt_q == BEATS_C);

endmodule

// File: rtl/pixel_beat_collector.sv
// Collects BEATS samples per pixel and writes one result per pixel to result memory.
// Define PIXEL_BEAT_COLLECTOR_AVG_EN to write the truncated average instead of the raw sum.
module pixel_beat_collector
    import pixel_beat_pkg::*;
#(
    parameter int BEATS             = DEFAULT_BEATS,
    parameter int PIXELCOUNTERWIDTH = DEFAULT_PIXELCOUNTERWIDTH,
    parameter int DATAWIDTH         = DEFAULT_DATAWIDTH,
    localparam int SUMWIDTH         = DATAWIDTH + 4
)(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         process,
    input  logic                         started,
    input  logic [PIXELCOUNTERWIDTH-1:0] pixelCounter,
    input  logic [DATAWIDTH-1:0]         dataIn,
    output logic                         wrEn,
    output logic [PIXELCOUNTERWIDTH-1:0] wrAddr,
    output logic [SUMWIDTH-1:0]          wrData,
    output logic                         frameDone,
    output logic                         beatError,
    output logic [PIXELCOUNTERWIDTH-1:0] pixelsWritten
);

    localparam int              CNTW    = $clog2(BEATS) + 1;
    localparam logic [CNTW-1:0] BEATS_C = CNTW'(BEATS);

    state_t state_q, state_d;

    logic [SUMWIDTH-1:0]          sum;
    logic [SUMWIDTH-1:0]          result;
    logic [CNTW-1:0]              beatCnt;
    logic                         overflow;
    logic                         beatValid;
    logic                         writeNow;
    logic                         frameStart;

    logic [PIXELCOUNTERWIDTH-1:0] addr_q, addr_d;
    logic                         wrEn_q, wrEn_d;
    logic [PIXELCOUNTERWIDTH-1:0] wrAddr_q, wrAddr_d;
    logic [SUMWIDTH-1:0]          wrData_q, wrData_d;
    logic                         beatError_q, beatError_d;
    logic [PIXELCOUNTERWIDTH-1:0] pixelsWritten_q, pixelsWritten_d;

    beat_accumulator #(
        .BEATS     (BEATS),
        .DATAWIDTH (DATAWIDTH),
        .SUMWIDTH  (SUMWIDTH),
        .CNTW      (CNTW)
    ) u_acc (
        .clk       (clk),
        .rst       (rst),
        .clear     (frameStart | writeNow),
        .beatValid (beatValid),
        .dataIn    (dataIn),
        .sum       (sum),
        .beatCnt   (beatCnt),
        .overflow  (overflow)
    );

`ifdef PIXEL_BEAT_COLLECTOR_AVG_EN
    localparam int SHIFT = $clog2(BEATS);
    assign result = sum >> SHIFT;
`else
    assign result = sum;
`endif

    // A falling started wins over any beat in the same cycle; the partial pixel is written from FLUSH.
    always_comb begin
        state_d    = state_q;
        frameStart = 1'b0;
        beatValid  = 1'b0;
        writeNow   = 1'b0;
        case (state_q)
            IDLE: begin
                if (started) begin
                    state_d    = ACCUM;
                    frameStart = 1'b1;
                end
            end
            ACCUM: begin
                if (!started) begin
                    state_d = FLUSH;
                end else if (process) begin
                    beatValid = 1'b1;
                end else if (beatCnt != '0) begin
                    writeNow = 1'b1;
                end
            end
            FLUSH: begin
                writeNow = (beatCnt != '0);
                state_d  = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        addr_d          = addr_q;
        wrEn_d          = writeNow;
        wrAddr_d        = wrAddr_q;
        wrData_d        = wrData_q;
        beatError_d     = beatError_q;
        pixelsWritten_d = pixelsWritten_q;
        if (frameStart) begin
            beatError_d     = 1'b0;
            pixelsWritten_d = '0;
        end
        if (beatValid && (beatCnt == '0)) begin
            addr_d = pixelCounter;
        end
        if (overflow) begin
            beatError_d = 1'b1;
        end
        if (writeNow) begin
            wrAddr_d        = addr_q;
            wrData_d        = result;
            pixelsWritten_d = pixelsWritten_q + PIXELCOUNTERWIDTH'(1);
            if (beatCnt != BEATS_C) begin
                beatError_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            wrEn_q          <= 1'b0;
            wrAddr_q        <= '0;
            wrData_q        <= '0;
            beatError_q     <= 1'b0;
            pixelsWritten_q <= '0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            wrEn_q          <= wrEn_d;
            wrAddr_q        <= wrAddr_d;
            wrData_q        <= wrData_d;
            beatError_q     <= beatError_d;
            pixelsWritten_q <= pixelsWritten_d;
        end
    end

    assign wrEn          = wrEn_q;
    assign wrAddr        = wrAddr_q;
    assign wrData        = wrData_q;
    assign frameDone     = (state_q == DONE);
    assign beatError     = beatError_q;
    assign pixelsWritten = pixelsWritten_q;

endmodule
